// File: rtl/cp0_intr_ctrl_pkg.sv
// cp0_intr_ctrl_pkg: shared CPU defines for the CP0 interrupt/timer controller.
// Holds the CP0 register numbers decoded on the write bus and the request FSM encoding.
package cp0_intr_ctrl_pkg;

  localparam int unsigned CP0_DATA_W = 32;
  localparam int unsigned CP0_IP_W   = 8;
  localparam int unsigned HW_IP_MAX  = 6;

  localparam logic [4:0] CP0_COUNT_ADDR   = 5'd9;
  localparam logic [4:0] CP0_COMPARE_ADDR = 5'd11;

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_REQ,
    IRQ_WAIT_EXL
  } irq_state_t;

endpackage

// File: rtl/cp0_intr_ctrl_sync.sv
// intr_sync: per-bit flop-chain synchroniser for asynchronous level inputs.
// Every bit passes through STAGES flops; all flops clear on reset.
module intr_sync #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] chain_q;

  // Shift raw input through the chain; oldest stage drives the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/cp0_intr_ctrl.sv
// cp0_intr_ctrl: CP0 interrupt and timer controller.
// Synchronises hardware lines, composes Cause.IP/TI, gates with Status and
// handshakes an interrupt request to the Exception unit.
// Optional macro INTR_TIMER_EN: builds the Count/Compare timer and prescaler;
// when undefined, count/compare/TI read as zero and timer writes are ignored.
module cp0_intr_ctrl
  import cp0_intr_ctrl_pkg::*;
#(
  parameter int unsigned HW_INT_NUM  = 6,
  parameter int unsigned COUNT_DIV   = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [HW_INT_NUM-1:0] hw_int_i,
  input  logic                  cp0_wr_i,
  input  logic [4:0]            cp0_wr_addr_i,
  input  logic [CP0_DATA_W-1:0] cp0_wr_data_i,
  input  logic                  status_ie_i,
  input  logic                  status_exl_i,
  input  logic [CP0_IP_W-1:0]   status_im_i,
  input  logic [1:0]            cause_ip_sw_i,
  input  logic                  irq_ack_i,
  output logic                  irq_req_o,
  output logic [CP0_IP_W-1:0]   cause_ip_o,
  output logic                  cause_ti_o,
  output logic [CP0_DATA_W-1:0] count_o,
  output logic [CP0_DATA_W-1:0] compare_o
);

  logic [HW_INT_NUM-1:0] hw_sync;
  logic [HW_IP_MAX-1:0]  hw_ip;
  logic                  ti;
  logic                  pending;
  irq_state_t            state_q;
  logic                  irq_req_q;

  intr_sync #(
    .WIDTH  (HW_INT_NUM),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (hw_int_i),
    .q_o (hw_sync)
  );

  // Unused hardware positions read as zero.
  assign hw_ip = HW_IP_MAX'(hw_sync);

`ifdef INTR_TIMER_EN
  localparam int unsigned PRE_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [CP0_DATA_W-1:0] count_q, count_d;
  logic [CP0_DATA_W-1:0] compare_q, compare_d;
  logic                  ti_q, ti_d;
  logic                  wr_count, wr_compare, pre_wrap, count_upd;

  // Next-state for prescaler, Count, Compare and the sticky TI flag.
  always_comb begin
    wr_count   = cp0_wr_i && (cp0_wr_addr_i == CP0_COUNT_ADDR);
    wr_compare = cp0_wr_i && (cp0_wr_addr_i == CP0_COMPARE_ADDR);
    pre_wrap   = (pre_q == PRE_W'(COUNT_DIV - 1));
    pre_d      = pre_wrap ? '0 : pre_q + PRE_W'(1);
    count_d    = count_q;
    count_upd  = 1'b0;
    compare_d  = compare_q;
    ti_d       = ti_q;

    // A Count write overrides any increment due on the same edge.
    if (wr_count) begin
      count_d   = cp0_wr_data_i;
      pre_d     = '0;
      count_upd = 1'b1;
    end else if (pre_wrap) begin
      count_d   = count_q + CP0_DATA_W'(1);
      count_upd = 1'b1;
    end

    // A Compare write clears TI and suppresses a same-edge match.
    if (wr_compare) begin
      compare_d = cp0_wr_data_i;
      ti_d      = 1'b0;
    end else if (count_upd && (count_d == compare_q)) begin
      ti_d = 1'b1;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q     <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti        = ti_q;
`else
  logic unused_timer_c;

  assign count_o   = '0;
  assign compare_o = '0;
  assign ti        = 1'b0;

  // Write bus and prescale setting have no consumer without the timer.
  assign unused_timer_c = ^{cp0_wr_i, cp0_wr_addr_i == CP0_COUNT_ADDR,
                            cp0_wr_addr_i == CP0_COMPARE_ADDR, cp0_wr_data_i,
                            32'(COUNT_DIV)};
`endif

  // Cause.IP composition: software bits, synced lines, TI folded into IP[7].
  assign cause_ip_o = {hw_ip[5] | ti, hw_ip[4:0], cause_ip_sw_i};
  assign cause_ti_o = ti;
  assign pending    = (|(cause_ip_o & status_im_i)) & status_ie_i & ~status_exl_i;

  // Request handshake FSM; WAIT_EXL blocks re-requests until EXL lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IRQ_IDLE;
      irq_req_q <= 1'b0;
    end else begin
      unique case (state_q)
        IRQ_IDLE: begin
          if (pending) begin
            state_q   <= IRQ_REQ;
            irq_req_q <= 1'b1;
          end
        end
        IRQ_REQ: begin
          if (irq_ack_i) begin
            state_q   <= IRQ_WAIT_EXL;
            irq_req_q <= 1'b0;
          end else if (!pending) begin
            state_q   <= IRQ_IDLE;
            irq_req_q <= 1'b0;
          end
        end
        IRQ_WAIT_EXL: begin
          if (status_exl_i) begin
            state_q <= IRQ_IDLE;
          end
        end
        default: begin
          state_q   <= IRQ_IDLE;
          irq_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign irq_req_o = irq_req_q;

endmodule

// File: tb/tb_cp0_intr_ctrl.sv
// tb_cp0_intr_ctrl: table-driven + scoreboard bench for cp0_intr_ctrl.
// Expected outputs are queued with the cycle they are due and checked #1 after that edge.
module tb_cp0_intr_ctrl;

  localparam int unsigned HW_INT_NUM  = 6;
  localparam int unsigned COUNT_DIV   = 2;
  localparam int unsigned SYNC_STAGES = 2;
`ifdef INTR_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  localparam bit [4:0] C_CNT = 5'b00001;
  localparam bit [4:0] C_CMP = 5'b00010;
  localparam bit [4:0] C_IP  = 5'b00100;
  localparam bit [4:0] C_TI  = 5'b01000;
  localparam bit [4:0] C_REQ = 5'b10000;
  localparam bit [4:0] C_ALL = 5'b11111;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [HW_INT_NUM-1:0] hw_int_i;
  logic                  cp0_wr_i;
  logic [4:0]            cp0_wr_addr_i;
  logic [31:0]           cp0_wr_data_i;
  logic                  status_ie_i;
  logic                  status_exl_i;
  logic [7:0]            status_im_i;
  logic [1:0]            cause_ip_sw_i;
  logic                  irq_ack_i;
  logic                  irq_req_o;
  logic [7:0]            cause_ip_o;
  logic                  cause_ti_o;
  logic [31:0]           count_o;
  logic [31:0]           compare_o;

  always #5 clk = ~clk;

  cp0_intr_ctrl #(
    .HW_INT_NUM  (HW_INT_NUM),
    .COUNT_DIV   (COUNT_DIV),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .hw_int_i      (hw_int_i),
    .cp0_wr_i      (cp0_wr_i),
    .cp0_wr_addr_i (cp0_wr_addr_i),
    .cp0_wr_data_i (cp0_wr_data_i),
    .status_ie_i   (status_ie_i),
    .status_exl_i  (status_exl_i),
    .status_im_i   (status_im_i),
    .cause_ip_sw_i (cause_ip_sw_i),
    .irq_ack_i     (irq_ack_i),
    .irq_req_o     (irq_req_o),
    .cause_ip_o    (cause_ip_o),
    .cause_ti_o    (cause_ti_o),
    .count_o       (count_o),
    .compare_o     (compare_o)
  );

  typedef struct {
    int unsigned at;
    string       name;
    bit [4:0]    chk;
    logic [31:0] cnt;
    logic [31:0] cmp;
    logic [7:0]  ip;
    logic        ti;
    logic        req;
  } exp_t;

  typedef struct {
    logic [5:0] hw;
    logic       ie;
    logic       exl;
    logic [7:0] im;
    logic [1:0] sw;
    logic [7:0] exp_ip;
    logic       exp_req;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[10];
  int unsigned cyc    = 0;
  int unsigned n_cmp  = 0;
  int unsigned n_bad  = 0;

  // Timer-dependent expectations collapse to zero when the timer is not built.
  function automatic logic [31:0] tv(input logic [31:0] v);
    return TIMER ? v : 32'h0;
  endfunction

  // Queue an expectation due ofs edges from now, kept sorted by due cycle.
  function automatic void push(input int unsigned ofs, input string nm, input bit [4:0] chk,
                               input logic [31:0] cnt, input logic [31:0] cmp,
                               input logic [7:0] ip, input logic ti, input logic req);
    exp_t e;
    int   pos;
    e.at = cyc + ofs; e.name = nm; e.chk = chk;
    e.cnt = cnt; e.cmp = cmp; e.ip = ip; e.ti = ti; e.req = req;
    pos = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].at > e.at) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, e);
  endfunction

  task automatic compare_exp(input exp_t e);
    bit ok;
    ok = 1'b1;
    if (e.chk[0] && (count_o    !== e.cnt)) ok = 1'b0;
    if (e.chk[1] && (compare_o  !== e.cmp)) ok = 1'b0;
    if (e.chk[2] && (cause_ip_o !== e.ip))  ok = 1'b0;
    if (e.chk[3] && (cause_ti_o !== e.ti))  ok = 1'b0;
    if (e.chk[4] && (irq_req_o  !== e.req)) ok = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s cyc=%0d chk=%b got cnt=%h cmp=%h ip=%h ti=%b req=%b want cnt=%h cmp=%h ip=%h ti=%b req=%b",
               e.name, cyc, e.chk, count_o, compare_o, cause_ip_o, cause_ti_o, irq_req_o,
               e.cnt, e.cmp, e.ip, e.ti, e.req);
    end
  endtask

  // Advance one edge, then retire every expectation due on it.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      compare_exp(e);
    end
  endtask

  task automatic cp0_write(input logic [4:0] a, input logic [31:0] d);
    cp0_wr_i      = 1'b1;
    cp0_wr_addr_i = a;
    cp0_wr_data_i = d;
    tick();
    cp0_wr_i      = 1'b0;
  endtask

  initial begin
    exp_t now_e;

    //          hw     ie    exl   im      sw     exp_ip  exp_req
    vecs[0] = '{6'h00, 1'b1, 1'b0, 8'hFF, 2'b00, 8'h00, 1'b0};
    vecs[1] = '{6'h01, 1'b1, 1'b0, 8'h04, 2'b00, 8'h04, 1'b1};
    vecs[2] = '{6'h3F, 1'b1, 1'b0, 8'h00, 2'b00, 8'hFC, 1'b0};
    vecs[3] = '{6'h3F, 1'b0, 1'b0, 8'hFF, 2'b00, 8'hFC, 1'b0};
    vecs[4] = '{6'h3F, 1'b1, 1'b1, 8'hFF, 2'b00, 8'hFC, 1'b0};
    vecs[5] = '{6'h00, 1'b1, 1'b0, 8'h01, 2'b01, 8'h01, 1'b1};
    vecs[6] = '{6'h20, 1'b1, 1'b0, 8'h80, 2'b00, 8'h80, 1'b1};
    vecs[7] = '{6'h20, 1'b1, 1'b0, 8'h7F, 2'b00, 8'h80, 1'b0};
    vecs[8] = '{6'h02, 1'b1, 1'b0, 8'h08, 2'b10, 8'h0A, 1'b1};
    vecs[9] = '{6'h10, 1'b1, 1'b0, 8'h20, 2'b00, 8'h40, 1'b0};

    rst = 1'b1; hw_int_i = '0; cp0_wr_i = 1'b0; cp0_wr_addr_i = '0; cp0_wr_data_i = '0;
    status_ie_i = 1'b0; status_exl_i = 1'b0; status_im_i = '0; cause_ip_sw_i = '0; irq_ack_i = 1'b0;
    tick(); tick();

    now_e = '{cyc, "reset_state", C_ALL, 32'h0, 32'h0, 8'h00, 1'b0, 1'b0};
    compare_exp(now_e);
    rst = 1'b0;

    // Prescaler: one increment per two clocks.
    push(10, "count_after_10", C_CNT, tv(32'd5), 0, 0, 0, 0);
    repeat (10) tick();

    // Count wrap; wrapping to 0 matches the reset Compare of 0.
    push(1, "count_load_max", C_CNT, tv(32'hFFFF_FFFF), 0, 0, 0, 0);
    push(3, "count_wrap", C_CNT | C_TI | C_IP, 32'h0, 0, {TIMER, 7'h0}, TIMER, 0);
    cp0_write(5'd9, 32'hFFFF_FFFF);
    tick(); tick();

    push(1, "ignore_other_addr", C_CNT | C_CMP, 32'h0, 32'h0, 0, 0, 0);
    cp0_write(5'd8, 32'hDEAD_BEEF);

    // Compare=8, Count=5 -> TI when Count reaches 8.
    push(1, "cmp8_clears_ti", C_CMP | C_TI, 0, tv(32'd8), 0, 1'b0, 0);
    cp0_write(5'd11, 32'd8);
    push(1, "count_load5", C_CNT | C_TI, tv(32'd5), 0, 0, 1'b0, 0);
    cp0_write(5'd9, 32'd5);
    push(5, "before_match8", C_CNT | C_TI | C_IP, tv(32'd7), 0, 8'h00, 1'b0, 0);
    push(6, "ti_on_match8", C_CNT | C_TI | C_IP, tv(32'd8), 0, {TIMER, 7'h0}, TIMER, 0);
    repeat (6) tick();

    // Compare=20 clears TI on its edge; TI returns when Count reaches 20.
    push(1, "cmp20_clears_ti", C_CNT | C_CMP | C_TI, tv(32'd8), tv(32'd20), 0, 1'b0, 0);
    cp0_write(5'd11, 32'd20);
    push(22, "before_match20", C_CNT | C_TI, tv(32'd19), 0, 0, 1'b0, 0);
    push(23, "ti_on_match20", C_CNT | C_TI, tv(32'd20), 0, 0, TIMER, 0);
    repeat (23) tick();

    // Count write beats a due increment; Compare write beats a same-edge match.
    push(1, "cmp40_clears_ti", C_CMP | C_TI, 0, tv(32'h40), 0, 1'b0, 0);
    cp0_write(5'd11, 32'h40);
    push(1, "count_write_wins", C_CNT | C_TI, tv(32'h3F), 0, 0, 1'b0, 0);
    cp0_write(5'd9, 32'h3F);
    tick();
    push(1, "cmp_write_beats_match", C_CNT | C_CMP | C_TI, tv(32'h40), tv(32'h50), 0, 1'b0, 0);
    cp0_write(5'd11, 32'h50);
    push(2, "ti_stays_clear", C_CNT | C_TI, tv(32'h41), 0, 0, 1'b0, 0);
    tick(); tick();

    // Park Compare far away so TI stays out of the gating vectors.
    cp0_write(5'd11, 32'hFFFF_0000);

    // Table-driven gating / composition vectors.
    for (int i = 0; i < 10; i++) begin
      hw_int_i = vecs[i].hw; status_ie_i = vecs[i].ie; status_exl_i = vecs[i].exl;
      status_im_i = vecs[i].im; cause_ip_sw_i = vecs[i].sw;
      push(4, $sformatf("vec%0d", i), C_IP | C_REQ, 0, 0, vecs[i].exp_ip, 0, vecs[i].exp_req);
      repeat (4) tick();
      hw_int_i = '0; cause_ip_sw_i = '0; status_im_i = '0; status_exl_i = 1'b0;
      push(4, $sformatf("vec%0d_clr", i), C_IP | C_REQ, 0, 0, 8'h00, 0, 1'b0);
      repeat (4) tick();
    end

    // Sync latency, request, ack, WAIT_EXL hold, re-request, withdraw.
    status_ie_i = 1'b1; status_im_i = 8'h04; hw_int_i = 6'h01;
    push(1, "irq_sync_stage1", C_IP | C_REQ, 0, 0, 8'h00, 0, 1'b0);
    push(2, "irq_ip_visible", C_IP | C_REQ, 0, 0, 8'h04, 0, 1'b0);
    push(3, "irq_req_rises", C_IP | C_REQ, 0, 0, 8'h04, 0, 1'b1);
    repeat (5) tick();
    irq_ack_i = 1'b1;
    push(1, "irq_ack_drops", C_REQ, 0, 0, 0, 0, 1'b0);
    tick();
    irq_ack_i = 1'b0;
    push(2, "irq_wait_exl_hold", C_REQ, 0, 0, 0, 0, 1'b0);
    repeat (2) tick();
    status_exl_i = 1'b1;
    push(1, "irq_exl_to_idle", C_REQ, 0, 0, 0, 0, 1'b0);
    tick();
    status_exl_i = 1'b0;
    push(1, "irq_rerequest", C_IP | C_REQ, 0, 0, 8'h04, 0, 1'b1);
    tick();
    hw_int_i = '0;
    push(2, "irq_withdraw_held", C_REQ, 0, 0, 0, 0, 1'b1);
    push(3, "irq_withdraw", C_IP | C_REQ, 0, 0, 8'h00, 0, 1'b0);
    repeat (3) tick();

    // Ack and pending drop on the same edge: ack wins.
    status_im_i = 8'h01; cause_ip_sw_i = 2'b01;
    push(1, "sw_req", C_IP | C_REQ, 0, 0, 8'h01, 0, 1'b1);
    tick();
    cause_ip_sw_i = 2'b00; irq_ack_i = 1'b1;
    push(1, "ack_beats_drop", C_REQ, 0, 0, 0, 0, 1'b0);
    tick();
    irq_ack_i = 1'b0; cause_ip_sw_i = 2'b01;
    push(2, "wait_exl_blocks", C_IP | C_REQ, 0, 0, 8'h01, 0, 1'b0);
    repeat (2) tick();
    status_exl_i = 1'b1;
    tick();
    status_exl_i = 1'b0;
    push(1, "sw_rerequest", C_REQ, 0, 0, 0, 0, 1'b1);
    tick();

    // Async reset while in WAIT_EXL with Count=0x1234.
    push(1, "count_1234", C_CNT, tv(32'h1234), 0, 0, 0, 0);
    cp0_write(5'd9, 32'h1234);
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    #2;
    cause_ip_sw_i = 2'b00;
    rst = 1'b1;
    #1;
    now_e = '{cyc, "rst_async", C_ALL, 32'h0, 32'h0, 8'h00, 1'b0, 1'b0};
    compare_exp(now_e);
    tick(); tick();
    rst = 1'b0; cause_ip_sw_i = 2'b01;
    push(1, "idle_after_reset", C_IP | C_REQ, 0, 0, 8'h01, 0, 1'b1);
    push(100, "count_after_100", C_CNT | C_CMP | C_TI, tv(32'd50), 32'h0, 0, 1'b0, 0);
    tick();
    cause_ip_sw_i = 2'b00;
    push(1, "final_withdraw", C_REQ, 0, 0, 0, 0, 1'b0);
    repeat (99) tick();

    while (sb.size() > 0) begin
      now_e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s never retired (due cyc=%0d, now cyc=%0d)", now_e.name, now_e.at, cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
